// File: rtl/ckpt_free_list.sv
// Speculative physical-register free list with branch checkpoints.
// A circular RAM of DEPTH tags is consumed at head and refilled at tail.
// Each checkpoint slot holds a head snapshot, so a mispredict restores head in one cycle.
// Flush recovery restores head from the architectural head.

module ckpt_free_list #(
  parameter int ALLOC_W  = 4,
  parameter int FREE_W   = 4,
  parameter int NUM_PHYS = 96,
  parameter int NUM_LOG  = 32,
  parameter int NUM_CKPT = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ALLOC_W-1:0]                   allocReq_i,
  input  logic                                 stall_i,
  output logic [ALLOC_W*$clog2(NUM_PHYS)-1:0]  freeTag_o,
  output logic                                 allocGrant_o,
  input  logic [FREE_W-1:0]                    freedValid_i,
  input  logic [FREE_W*$clog2(NUM_PHYS)-1:0]   freedTag_i,
  input  logic [$clog2(ALLOC_W):0]             commitAllocCnt_i,
  input  logic                                 ckptReq_i,
  output logic [$clog2(NUM_CKPT)-1:0]          ckptId_o,
  output logic                                 ckptFull_o,
  input  logic                                 ckptRetire_i,
  input  logic                                 restoreValid_i,
  input  logic [$clog2(NUM_CKPT)-1:0]          restoreId_i,
  input  logic                                 recoverFlag_i,
  output logic [$clog2(NUM_PHYS-NUM_LOG):0]    freeCount_o,
  output logic                                 freeListEmpty_o
);

  localparam int DEPTH  = NUM_PHYS - NUM_LOG;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int TAG_W  = $clog2(NUM_PHYS);
  localparam int CK_W   = $clog2(NUM_CKPT);
  localparam int CCNT_W = CK_W + 1;
  localparam int ACNT_W = $clog2(ALLOC_W) + 1;
  localparam int FCNT_W = $clog2(FREE_W) + 1;

  logic [TAG_W-1:0]  ram [DEPTH];
  logic [PTR_W-1:0]  ck_mem [NUM_CKPT];
  logic [PTR_W-1:0]  free_wr_ptr [FREE_W];

  logic [PTR_W-1:0]  head, tail, arch_head;
  logic [PTR_W-1:0]  head_nxt, tail_nxt, arch_nxt, free_count, snap;
  logic [CK_W-1:0]   ck_head, ck_tail, ck_head_nxt, ck_tail_nxt, kept;
  logic [CCNT_W-1:0] ck_count, ck_count_nxt;
  logic [ACNT_W-1:0] alloc_cnt;
  logic [FCNT_W-1:0] free_cnt;
  logic              grant, ck_take, retire_ok;

  function automatic logic [ACNT_W-1:0] count_alloc(input logic [ALLOC_W-1:0] v);
    logic [ACNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      s = s + ACNT_W'(v[i]);
    end
    return s;
  endfunction

  function automatic logic [FCNT_W-1:0] count_free(input logic [FREE_W-1:0] v);
    logic [FCNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < FREE_W; i++) begin
      s = s + FCNT_W'(v[i]);
    end
    return s;
  endfunction

  // Occupancy, exhaustion and the all-or-nothing allocation grant.
  always_comb begin
    alloc_cnt       = count_alloc(allocReq_i);
    free_cnt        = count_free(freedValid_i);
    free_count      = tail - head;
    freeCount_o     = free_count;
    freeListEmpty_o = (free_count < PTR_W'(alloc_cnt));
    ckptFull_o      = (ck_count == CCNT_W'(NUM_CKPT));
    ckptId_o        = ck_tail;
    grant           = reset && (|allocReq_i) && !stall_i && !freeListEmpty_o &&
                      !restoreValid_i && !recoverFlag_i;
    allocGrant_o    = grant;
  end

  // Present the next ALLOC_W tags from head in lane order; the consumer compacts.
  always_comb begin
    freeTag_o = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      freeTag_o[i*TAG_W +: TAG_W] = ram[IDX_W'(head + PTR_W'(i))];
    end
  end

  // Compacted write slots for returned tags: each valid lane takes the next tail slot.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int j = 0; j < FREE_W; j++) begin
      free_wr_ptr[j] = tail + off;
      off            = off + PTR_W'(freedValid_i[j]);
    end
  end

  // Pointer and checkpoint-queue next state, ordered recover > restore > allocate.
  always_comb begin
    snap      = head + (grant ? PTR_W'(alloc_cnt) : '0);
    ck_take   = ckptReq_i && !stall_i && !ckptFull_o && !restoreValid_i && !recoverFlag_i;
    retire_ok = ckptRetire_i && (ck_count != '0);
    arch_nxt  = arch_head + PTR_W'(commitAllocCnt_i);
    tail_nxt  = tail + PTR_W'(free_cnt);
    // Slots older than the restored one survive; the restored slot and younger are freed.
    kept      = restoreId_i - ck_head;
    if (recoverFlag_i) begin
      head_nxt     = arch_nxt;
      ck_head_nxt  = ck_tail;
      ck_tail_nxt  = ck_tail;
      ck_count_nxt = '0;
    end else if (restoreValid_i) begin
      head_nxt     = ck_mem[restoreId_i];
      ck_tail_nxt  = restoreId_i;
      ck_head_nxt  = ck_head + CK_W'(retire_ok);
      ck_count_nxt = {1'b0, kept} - CCNT_W'(retire_ok);
    end else begin
      head_nxt     = grant ? (head + PTR_W'(alloc_cnt)) : head;
      ck_tail_nxt  = ck_tail + CK_W'(ck_take);
      ck_head_nxt  = ck_head + CK_W'(retire_ok);
      ck_count_nxt = ck_count + CCNT_W'(ck_take) - CCNT_W'(retire_ok);
    end
  end

  // Pointer registers; tail starts one full lap ahead so all DEPTH entries are free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= PTR_W'(DEPTH);
      arch_head <= '0;
      ck_head   <= '0;
      ck_tail   <= '0;
      ck_count  <= '0;
    end else begin
      head      <= head_nxt;
      tail      <= tail_nxt;
      arch_head <= arch_nxt;
      ck_head   <= ck_head_nxt;
      ck_tail   <= ck_tail_nxt;
      ck_count  <= ck_count_nxt;
    end
  end

  // Tag RAM: reloaded with NUM_LOG+k in parallel on reset, refilled from commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        ram[k] <= TAG_W'(NUM_LOG + k);
      end
    end else begin
      for (int j = 0; j < FREE_W; j++) begin
        if (freedValid_i[j]) begin
          ram[free_wr_ptr[j][IDX_W-1:0]] <= freedTag_i[j*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Checkpoint snapshots hold the post-allocation head of the snapshot cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CKPT; k++) begin
        ck_mem[k] <= '0;
      end
    end else if (ck_take) begin
      ck_mem[ck_tail] <= snap;
    end
  end

  ckpt_free_list_chk #(
    .PTR_W (PTR_W),
    .CK_W  (CK_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .free_count    (free_count),
    .restore_valid (restoreValid_i),
    .restore_id    (restoreId_i),
    .retire        (ckptRetire_i),
    .ck_head       (ck_head),
    .ck_count      (ck_count)
  );

endmodule

// Simulation-only checks of usage rules the free list relies on.
module ckpt_free_list_chk #(
  parameter int PTR_W = 7,
  parameter int CK_W  = 3,
  parameter int DEPTH = 64
) (
  input logic             clk,
  input logic             reset,
  input logic [PTR_W-1:0] free_count,
  input logic             restore_valid,
  input logic [CK_W-1:0]  restore_id,
  input logic             retire,
  input logic [CK_W-1:0]  ck_head,
  input logic [CK_W:0]    ck_count
);

  // More tags returned than the list can hold.
  a_no_overfill: assert property (@(posedge clk) disable iff (!reset)
    free_count <= PTR_W'(DEPTH));

  // Retiring the very slot that is being restored in the same cycle.
  a_no_retire_restored: assert property (@(posedge clk) disable iff (!reset)
    !(restore_valid && retire && (ck_count != '0) && (restore_id == ck_head)));

endmodule
